mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised successor to the core's unified instruction/data memory front end. It holds a byte-writable dual-port memory array of `DEPTH` lines of `LINE_BYTES` bytes. Port A serves instruction fetches. Port B serves load/store requests through a valid/ready handshake, with sign extension, a per-request response and fault reporting. It sits between the fetch/memory pipeline stages and the on-chip RAM.

## Interface
Parameters:
- `LINE_BYTES`, 8: bytes per memory line; power of two, ≥4.
- `DEPTH`, 16384: number of lines; line index width `IDX_W = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_req`  in  1  fetch request this cycle.
- `i_addr`  in  32  fetch byte address.
- `i_valid`  out  1  fetched word valid.
- `i_instr`  out  32  fetched word.
- `i_fault`  out  1  fetch fault, qualified by `i_valid`.
- `d_req_valid`  in  1  data request valid.
- `d_req_ready`  out  1  unit can accept a data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data, right-aligned.
- `d_dw`  in  `data_width`  access size: DB, DH or DW.
- `d_sign`  in  1  sign-extend a load result (LB/LH); 0 = zero-extend.
- `d_resp_valid`  out  1  response pulse for the accepted request.
- `d_rdata`  out  32  formatted load data; 0 for stores and faults.
- `d_fault`  out  1  request faulted, qualified by `d_resp_valid`.

## Operation
- Line index = `addr / LINE_BYTES`. Byte offset = `addr % LINE_BYTES`.
- Out of range: index ≥ `DEPTH` is a fault. On a fault:
  - no array access;
  - rdata/instr = 0.
- Fetch port:
  - `i_req` in cycle N → `i_valid` = 1 in N+1.
  - `i_instr` = the 32-bit word at offset `addr[log2(LINE_BYTES)-1:2]` of the line.
  - A fetch is never stalled; there is one result per request.
- Data port FSM:
  - States: IDLE, LOAD_RD, RESP.
  - `d_req_ready` = 1 only in IDLE.
  - A handshake occurs when `d_req_valid && d_req_ready`.
- IDLE transitions:
  - store accepted → array written at the same edge, go to RESP;
  - load accepted → array read, go to LOAD_RD;
  - fault → go to RESP with `d_fault` = 1.
- LOAD_RD: the line is captured; extract the bytes at the offset, extend them per `d_dw`/`d_sign`, register the result, go to RESP.
- RESP: drive `d_resp_valid` = 1 for one cycle, return to IDLE. `d_req_ready` rises in the following cycle.
- Store byte enables = `mask(d_dw) << offset`. Write data = `d_wdata << (offset*8)`. Bytes outside the mask are unchanged.
- Extension rules:
  - DB: bit 7 replicated when `d_sign`, else zero.
  - DH: bit 15 replicated when `d_sign`, else zero.
  - DW: unmodified.
- Request fields are latched at handshake. Input changes after acceptance have no effect.
- Collision: a fetch and a store to the same line in the same cycle. The fetch returns the old data (read-first); a fetch one cycle later returns the new data.
- Reset:
  - `i_valid`, `i_instr`, `i_fault`, `d_resp_valid`, `d_rdata`, `d_fault` = 0;
  - `d_req_ready` = 1, FSM = IDLE.
  - Array contents are not reset.
  - Reset mid-operation drops any pending response. A store committed before the reset edge stays written.

## Timing
- Fetch latency: 1 cycle; throughput 1 per cycle.
- Store: accept at edge N → `d_resp_valid` in cycle N+1; next accept at the earliest in N+2.
- Load: accept at edge N → `d_resp_valid`/`d_rdata` in cycle N+2; next accept in N+3.
- Fault: response in N+1, same as a store.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MEM_MISALIGN_FAULT_EN`
  - Defined: DH with `addr[0]` ≠ 0, or DW with `addr[1:0]` ≠ 0, faults on either port (a fetch faults when `i_addr[1:0]` ≠ 0).
  - Undefined: the low address bits are forced to natural alignment (DH clears bit 0, DW and fetch clear bits 1:0), and the access proceeds with no fault.
  - Out-of-range faults are unaffected by the macro.

## Test plan
- Reset → `d_req_ready` = 1 and all other outputs 0. Fetch at 0x8 after preloading line 1 = 0x11223344_55667788 (`LINE_BYTES`=8) → `i_instr` = 0x55667788 one cycle later. Fetch at 0xC → 0x11223344.
- SW 0xDEADBEEF at 0x10, then LB `d_sign`=1 at 0x10 → response 0xFFFFFFEF two cycles after accept. LBU at 0x13 → 0x000000DE.
- SH 0x8001 at 0x22 over a line holding 0x0 → `d_resp_valid` one cycle after accept. LH `d_sign`=1 at 0x22 → 0xFFFF8001. LW at 0x20 → 0x80010000.
- Same-cycle store 0xAAAAAAAA at 0x30 and fetch at 0x30, line previously 0 → `i_instr` = 0; fetch at 0x30 next cycle → 0xAAAAAAAA.
- LW at 0x31 with the macro defined → `d_fault` = 1, `d_rdata` = 0 in N+1. Without the macro → data from 0x30.
- Load to index `DEPTH` → fault. Assert `rst` in LOAD_RD → no `d_resp_valid`, and `d_req_ready` = 1 after reset.

Source files
------------

// File: rtl/mem_access_unit.sv
// Unified instruction/data memory front end: byte-writable line array, fetch port A, load/store port B.
// Optional define MEM_MISALIGN_FAULT_EN turns misaligned accesses into faults instead of force-aligning them.

package mem_access_unit_pkg;
  typedef enum logic [1:0] {DB = 2'd0, DH = 2'd1, DW = 2'd2} data_width;
endpackage

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int LINE_BYTES = 8,
  parameter int DEPTH      = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_instr,
  output logic        i_fault,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  data_width   d_dw,
  input  logic        d_sign,
  output logic        d_resp_valid,
  output logic [31:0] d_rdata,
  output logic        d_fault
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int WOFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_RD, RESP} state_t;

  logic [LINE_W-1:0] mem_q [DEPTH];

  logic [31:0]       fLineIdx;
  logic              fOor, fMis, fFault;
  logic [IDX_W-1:0]  fIdx;
  logic [WOFF_W-1:0] fWord;
  logic              iValid_q, iFault_q;
  logic [31:0]       iInstr_q;

  assign fLineIdx = i_addr >> OFF_W;
  assign fOor     = fLineIdx >= 32'(DEPTH);
`ifdef MEM_MISALIGN_FAULT_EN
  assign fMis     = i_addr[1:0] != 2'b00;
`else
  assign fMis     = 1'b0;
`endif
  assign fFault   = fOor || fMis;
  assign fIdx     = fLineIdx[IDX_W-1:0];
  assign fWord    = (WORDS > 1) ? WOFF_W'(i_addr >> 2) : '0;

  // Fetch reads old line contents when a store hits the same line this edge (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      iValid_q <= 1'b0;
      iFault_q <= 1'b0;
      iInstr_q <= '0;
    end else begin
      iValid_q <= i_req;
      iFault_q <= i_req && fFault;
      iInstr_q <= (i_req && !fFault) ? mem_q[fIdx][{fWord, 5'd0} +: 32] : '0;
    end
  end

  assign i_valid = iValid_q;
  assign i_instr = iInstr_q;
  assign i_fault = iFault_q;

  logic [31:0]       dAddrAl;
  logic              dMis, dOor, dFault, dHandshake;
  logic [31:0]       dLineIdx;
  logic [IDX_W-1:0]  dIdx;
  logic [OFF_W-1:0]  dOff;
  logic [3:0]        dMask;
  logic [LINE_BYTES-1:0] dBe;
  logic [LINE_W-1:0] dWLine;

  always_comb begin
    dAddrAl = d_addr;
    dMis    = 1'b0;
    dMask   = 4'b1111;
    case (d_dw)
      DB: dMask = 4'b0001;
      DH: begin
        dMask = 4'b0011;
`ifdef MEM_MISALIGN_FAULT_EN
        dMis = d_addr[0];
`else
        dAddrAl[0] = 1'b0;
`endif
      end
      default: begin
`ifdef MEM_MISALIGN_FAULT_EN
        dMis = |d_addr[1:0];
`else
        dAddrAl[1:0] = 2'b00;
`endif
      end
    endcase
  end

  assign dLineIdx   = dAddrAl >> OFF_W;
  assign dOor       = dLineIdx >= 32'(DEPTH);
  assign dFault     = dOor || dMis;
  assign dIdx       = dLineIdx[IDX_W-1:0];
  assign dOff       = dAddrAl[OFF_W-1:0];
  assign dBe        = LINE_BYTES'(dMask) << dOff;
  assign dWLine     = LINE_W'(d_wdata) << {dOff, 3'b000};
  assign dHandshake = d_req_valid && d_req_ready;

  state_t            state_q, state_d;
  logic              dReady_q, dReady_d;
  logic              dRespValid_q, dRespValid_d;
  logic [31:0]       dRdata_q, dRdata_d;
  logic              dFault_q, dFault_d;
  logic [OFF_W-1:0]  off_q, off_d;
  data_width         dw_q, dw_d;
  logic              sign_q, sign_d;
  logic              storeEn, loadEn;
  logic [LINE_W-1:0] ldLine_q;
  logic [WOFF_W-1:0] ldWordIdx;
  logic [31:0]       ldWord, ldAligned, ldExt;

  always_ff @(posedge clk) begin
    if (storeEn && !rst) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (dBe[b]) mem_q[dIdx][8*b +: 8] <= dWLine[8*b +: 8];
      end
    end
    if (loadEn) ldLine_q <= mem_q[dIdx];
  end

  // Alignment keeps every access inside one 32-bit word of the captured line.
  assign ldWordIdx = (WORDS > 1) ? WOFF_W'(off_q >> 2) : '0;
  assign ldWord    = ldLine_q[{ldWordIdx, 5'd0} +: 32];
  assign ldAligned = ldWord >> {off_q[1:0], 3'b000};

  always_comb begin
    ldExt = ldAligned;
    case (dw_q)
      DB: ldExt = sign_q ? {{24{ldAligned[7]}}, ldAligned[7:0]} : {24'd0, ldAligned[7:0]};
      DH: ldExt = sign_q ? {{16{ldAligned[15]}}, ldAligned[15:0]} : {16'd0, ldAligned[15:0]};
      default: ldExt = ldAligned;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dRespValid_d = 1'b0;
    dRdata_d     = '0;
    dFault_d     = 1'b0;
    off_d        = off_q;
    dw_d         = dw_q;
    sign_d       = sign_q;
    storeEn      = 1'b0;
    loadEn       = 1'b0;
    case (state_q)
      IDLE: begin
        if (dHandshake) begin
          if (dFault) begin
            state_d      = RESP;
            dRespValid_d = 1'b1;
            dFault_d     = 1'b1;
          end else if (d_we) begin
            storeEn      = 1'b1;
            state_d      = RESP;
            dRespValid_d = 1'b1;
          end else begin
            loadEn  = 1'b1;
            off_d   = dOff;
            dw_d    = d_dw;
            sign_d  = d_sign;
            state_d = LOAD_RD;
          end
        end
      end
      LOAD_RD: begin
        dRdata_d     = ldExt;
        dRespValid_d = 1'b1;
        state_d      = RESP;
      end
      default: state_d = IDLE;
    endcase
    dReady_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dReady_q     <= 1'b1;
      dRespValid_q <= 1'b0;
      dRdata_q     <= '0;
      dFault_q     <= 1'b0;
      off_q        <= '0;
      dw_q         <= DW;
      sign_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dReady_q     <= dReady_d;
      dRespValid_q <= dRespValid_d;
      dRdata_q     <= dRdata_d;
      dFault_q     <= dFault_d;
      off_q        <= off_d;
      dw_q         <= dw_d;
      sign_q       <= sign_d;
    end
  end

  assign d_req_ready  = dReady_q;
  assign d_resp_valid = dRespValid_q;
  assign d_rdata      = dRdata_q;
  assign d_fault      = dFault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit; honours MEM_MISALIGN_FAULT_EN when defined.

module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int LB  = 8;
  localparam int DEP = 256;

  logic        clk, rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_valid, i_fault;
  logic [31:0] i_instr;
  logic        d_req_valid, d_req_ready, d_we, d_sign;
  logic [31:0] d_addr, d_wdata, d_rdata;
  data_width   d_dw;
  logic        d_resp_valid, d_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  logic sawResp;

  mem_access_unit #(.LINE_BYTES(LB), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_instr(i_instr), .i_fault(i_fault),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_dw(d_dw), .d_sign(d_sign),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_fault(d_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; drives one data request and scrambles the fields right after acceptance.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input data_width dw, input logic sign,
                               input logic [31:0] expRdata, input logic expFault, input int expLat);
    exp_t x;
    check("ready_before_req", 32'(d_req_ready), 32'd1);
    d_req_valid = 1'b1;
    d_we        = we;
    d_addr      = addr;
    d_wdata     = wdata;
    d_dw        = dw;
    d_sign      = sign;
    x.rdata = expRdata;
    x.fault = expFault;
    x.lat   = expLat;
    expQ.push_back(x);
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    d_we        = ~we;
    d_addr      = addr ^ 32'h0000_0005;
    d_wdata     = ~wdata;
    d_dw        = (dw == DW) ? DB : DW;
    d_sign      = ~sign;
  endtask

  task automatic checkOutput(input string tag);
    int   lat;
    exp_t x;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!d_resp_valid && lat < 6);
    if (expQ.size() > 0) x = expQ.pop_front();
    else begin
      x.rdata = '0; x.fault = 1'b0; x.lat = -1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(x.lat));
    check({tag, "_rdata"}, d_rdata, x.rdata);
    check({tag, "_fault"}, 32'(d_fault), 32'(x.fault));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(d_resp_valid), 32'd0);
    check({tag, "_ready"}, 32'(d_req_ready), 32'd1);
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] expInstr, input logic expFault);
    i_req  = 1'b1;
    i_addr = addr;
    @(negedge clk);
    i_req  = 1'b0;
    i_addr = ~addr;
    check({tag, "_valid"}, 32'(i_valid), 32'd1);
    check({tag, "_instr"}, i_instr, expInstr);
    check({tag, "_fault"}, 32'(i_fault), 32'(expFault));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_dw = DW; d_sign = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 32'(d_req_ready), 32'd1);
    check("rst_ivalid", 32'(i_valid), 32'd0);
    check("rst_instr", i_instr, 32'd0);
    check("rst_ifault", 32'(i_fault), 32'd0);
    check("rst_resp", 32'(d_resp_valid), 32'd0);
    check("rst_rdata", d_rdata, 32'd0);
    check("rst_dfault", 32'(d_fault), 32'd0);

    applyStimulus(1'b1, 32'h08, 32'h5566_7788, DW, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("pre_lo");
    applyStimulus(1'b1, 32'h0C, 32'h1122_3344, DW, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("pre_hi");
    checkFetch("fetch_08", 32'h08, 32'h5566_7788, 1'b0);
    checkFetch("fetch_0c", 32'h0C, 32'h1122_3344, 1'b0);

    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, DW, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("sw_10");
    applyStimulus(1'b0, 32'h10, 32'h0, DB, 1'b1, 32'hFFFF_FFEF, 1'b0, 2);
    checkOutput("lb_10");
    applyStimulus(1'b0, 32'h13, 32'h0, DB, 1'b0, 32'h0000_00DE, 1'b0, 2);
    checkOutput("lbu_13");
    applyStimulus(1'b0, 32'h11, 32'h0, DB, 1'b1, 32'hFFFF_FFBE, 1'b0, 2);
    checkOutput("lb_11");

    applyStimulus(1'b1, 32'h20, 32'h0, DW, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("clr_20");
    applyStimulus(1'b1, 32'h24, 32'h0, DW, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("clr_24");
    applyStimulus(1'b1, 32'h22, 32'h1234_8001, DH, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("sh_22");
    applyStimulus(1'b0, 32'h22, 32'h0, DH, 1'b1, 32'hFFFF_8001, 1'b0, 2);
    checkOutput("lh_22");
    applyStimulus(1'b0, 32'h22, 32'h0, DH, 1'b0, 32'h0000_8001, 1'b0, 2);
    checkOutput("lhu_22");
    applyStimulus(1'b0, 32'h20, 32'h0, DW, 1'b0, 32'h8001_0000, 1'b0, 2);
    checkOutput("lw_20");

    applyStimulus(1'b1, 32'h30, 32'h0, DW, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("clr_30");

    // Same-cycle store and fetch to line 6, then fetch again the cycle after.
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hAAAA_AAAA; d_dw = DW; d_sign = 1'b0;
    i_req = 1'b1; i_addr = 32'h30;
    e.rdata = '0; e.fault = 1'b0; e.lat = 1;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    check("coll_old_instr", i_instr, 32'h0);
    e = expQ.pop_front();
    check("coll_store_resp", 32'(d_resp_valid), 32'd1);
    check("coll_store_fault", 32'(d_fault), 32'(e.fault));
    @(negedge clk);
    i_req = 1'b0;
    check("coll_new_instr", i_instr, 32'hAAAA_AAAA);
    check("coll_new_valid", 32'(i_valid), 32'd1);

`ifdef MEM_MISALIGN_FAULT_EN
    applyStimulus(1'b0, 32'h31, 32'h0, DW, 1'b0, 32'h0, 1'b1, 1);
    checkOutput("lw_31_mis");
    checkFetch("fetch_32_mis", 32'h32, 32'h0, 1'b1);
`else
    applyStimulus(1'b0, 32'h31, 32'h0, DW, 1'b0, 32'hAAAA_AAAA, 1'b0, 2);
    checkOutput("lw_31_align");
    checkFetch("fetch_32_align", 32'h32, 32'hAAAA_AAAA, 1'b0);
`endif

    applyStimulus(1'b1, 32'((DEP - 1) * LB), 32'h0BAD_F00D, DW, 1'b0, 32'h0, 1'b0, 1);
    checkOutput("sw_last");
    checkFetch("fetch_last", 32'((DEP - 1) * LB), 32'h0BAD_F00D, 1'b0);
    applyStimulus(1'b0, 32'(DEP * LB), 32'h0, DW, 1'b0, 32'h0, 1'b1, 1);
    checkOutput("lw_oor");
    applyStimulus(1'b1, 32'(DEP * LB + 16), 32'h1234_5678, DW, 1'b0, 32'h0, 1'b1, 1);
    checkOutput("sw_oor");
    checkFetch("fetch_oor", 32'(DEP * LB), 32'h0, 1'b1);

    // Reset while the load sits in LOAD_RD must drop its response.
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_dw = DW; d_sign = 1'b0;
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sawResp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (d_resp_valid) sawResp = 1'b1;
    end
    check("rst_mid_no_resp", 32'(sawResp), 32'd0);
    check("rst_mid_ready", 32'(d_req_ready), 32'd1);
    check("rst_mid_rdata", d_rdata, 32'd0);

    applyStimulus(1'b0, 32'h10, 32'h0, DW, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);
    checkOutput("lw_10_after");

    check("sb_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
